// File: rtl/pipeline_arbiter.sv
// pipeline_arbiter: round-robin issue, ID tagging and response routing that shares one pipeline among NUM_REQ requesters.
// Per-requester flush/drain support is built only when PIPELINE_ARB_FLUSH_EN is defined.
module pipeline_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int REQ_BITS      = 2,
    parameter int MAX_OUT       = 8,
    parameter int ADDRESS_WIDTH = 32,
    parameter int ID_WIDTH      = 8
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_REQ*ADDRESS_WIDTH-1:0] req_address,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_stall,
    input  logic [NUM_REQ-1:0]               req_flush,
    output logic [NUM_REQ-1:0]               flush_ack,
    output logic [ADDRESS_WIDTH-1:0]         resp_address,
    output logic [ID_WIDTH-1:0]              resp_id,
    output logic [NUM_REQ-1:0]               resp_valid,
    input  logic [NUM_REQ-1:0]               resp_stall,
    output logic [NUM_REQ-1:0]               busy,
    output logic [ADDRESS_WIDTH-1:0]         pl_address,
    output logic [ID_WIDTH-1:0]              pl_id,
    output logic                             pl_valid,
    input  logic                             pl_stall,
    output logic                             pl_flush,
    output logic [ID_WIDTH-1:0]              pl_flush_id,
    input  logic [ADDRESS_WIDTH-1:0]         pl_out_address,
    input  logic [ID_WIDTH-1:0]              pl_out_id,
    input  logic                             pl_out_valid,
    output logic                             pl_out_stall,
    input  logic                             pl_out_flush
);
    localparam int SEQ_W = ID_WIDTH - REQ_BITS;
    localparam int CNT_W = $clog2(MAX_OUT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

    // Issue slot
    logic                     slot_valid_q, slot_valid_d;
    logic [ADDRESS_WIDTH-1:0] slot_addr_q, slot_addr_d;
    logic [ID_WIDTH-1:0]      slot_id_q, slot_id_d;

    // Arbitration and per-requester bookkeeping
    logic [REQ_BITS-1:0] ptr_q, ptr_d;
    logic [SEQ_W-1:0]    seq_q [NUM_REQ];
    logic [SEQ_W-1:0]    seq_d [NUM_REQ];
    logic [CNT_W-1:0]    cnt_q [NUM_REQ];
    logic [CNT_W-1:0]    cnt_d [NUM_REQ];

    logic [NUM_REQ-1:0]  full;
    logic [NUM_REQ-1:0]  eligible;
    logic                slot_load;
    logic                grant_any;
    logic [REQ_BITS-1:0] grant_idx;
    logic [NUM_REQ-1:0]  grant_hot;

    // Response routing
    logic [REQ_BITS-1:0] resp_owner;
    logic [NUM_REQ-1:0]  owner_hot;
    logic                owner_drain;
    logic [NUM_REQ-1:0]  resp_hot;

    // Flush-side signals shared with the rest of the datapath
    logic [NUM_REQ-1:0]  drain;
    logic [NUM_REQ-1:0]  flush_hot;
    logic [NUM_REQ-1:0]  clear_hot;

`ifdef PIPELINE_ARB_FLUSH_EN
    localparam int FCNT_W = REQ_BITS + 1;

    logic [NUM_REQ-1:0]  drain_q, drain_d;
    logic                flush_fire;
    logic [REQ_BITS-1:0] flush_idx;
    logic [REQ_BITS-1:0] fifo_q [NUM_REQ];
    logic [REQ_BITS-1:0] wr_q, rd_q;
    logic [FCNT_W-1:0]   fcnt_q;
    logic                pop;
    logic                pl_flush_q;
    logic [ID_WIDTH-1:0] pl_flush_id_q;
    logic [NUM_REQ-1:0]  flush_ack_q;

    // Lowest-index requester that is not already draining wins the flush slot.
    always_comb begin
        flush_fire = 1'b0;
        flush_idx  = '0;
        flush_hot  = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (!flush_fire && req_flush[r] && !drain_q[r]) begin
                flush_fire   = 1'b1;
                flush_idx    = REQ_BITS'(r);
                flush_hot[r] = 1'b1;
            end
        end
    end

    assign pop       = pl_out_flush && (fcnt_q != '0);
    assign clear_hot = pop ? (NUM_REQ'(1) << fifo_q[rd_q]) : '0;
    assign drain_d   = (drain_q | flush_hot) & ~clear_hot;
    assign drain     = drain_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            drain_q       <= '0;
            wr_q          <= '0;
            rd_q          <= '0;
            fcnt_q        <= '0;
            pl_flush_q    <= 1'b0;
            pl_flush_id_q <= '0;
            flush_ack_q   <= '0;
        end else begin
            drain_q <= drain_d;
            if (flush_fire) begin
                fifo_q[wr_q] <= flush_idx;
                wr_q         <= wr_q + REQ_BITS'(1);
            end
            if (pop) begin
                rd_q <= rd_q + REQ_BITS'(1);
            end
            if (flush_fire && !pop) begin
                fcnt_q <= fcnt_q + FCNT_W'(1);
            end else if (!flush_fire && pop) begin
                fcnt_q <= fcnt_q - FCNT_W'(1);
            end
            pl_flush_q    <= flush_fire;
            pl_flush_id_q <= flush_fire ? {flush_idx, seq_q[flush_idx]} : '0;
            flush_ack_q   <= flush_hot;
        end
    end

    assign pl_flush    = pl_flush_q;
    assign pl_flush_id = pl_flush_id_q;
    assign flush_ack   = flush_ack_q;
`else
    logic unused_flush_inputs;

    assign unused_flush_inputs = ^{req_flush, pl_out_flush};
    assign drain       = '0;
    assign flush_hot   = '0;
    assign clear_hot   = '0;
    assign pl_flush    = 1'b0;
    assign pl_flush_id = '0;
    assign flush_ack   = '0;
`endif

    always_comb begin
        full = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            full[r] = (cnt_q[r] == MAX_CNT);
        end
    end

    assign eligible  = req_valid & ~full & ~drain & ~flush_hot;
    assign slot_load = reset && (!slot_valid_q || !pl_stall);

    // Scan from the pointer; the REQ_BITS-wide sum wraps modulo NUM_REQ.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_any && eligible[ptr_q + REQ_BITS'(k)]) begin
                grant_any = 1'b1;
                grant_idx = ptr_q + REQ_BITS'(k);
            end
        end
    end

    assign grant_hot = (slot_load && grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign req_stall = ~grant_hot;

    assign resp_owner   = pl_out_id[ID_WIDTH-1 -: REQ_BITS];
    assign owner_hot    = NUM_REQ'(1) << resp_owner;
    assign owner_drain  = |(owner_hot & drain);
    assign resp_valid   = (pl_out_valid && !owner_drain) ? owner_hot : '0;
    assign pl_out_stall = pl_out_valid && !owner_drain && |(owner_hot & resp_stall);
    assign resp_hot     = (pl_out_valid && !pl_out_stall) ? owner_hot : '0;
    assign resp_address = pl_out_address;
    assign resp_id      = pl_out_id;

    always_comb begin
        slot_valid_d = slot_valid_q;
        slot_addr_d  = slot_addr_q;
        slot_id_d    = slot_id_q;
        ptr_d        = ptr_q;
        seq_d        = seq_q;
        cnt_d        = cnt_q;
        if (slot_load) begin
            slot_valid_d = grant_any;
            if (grant_any) begin
                slot_addr_d      = req_address[grant_idx*ADDRESS_WIDTH +: ADDRESS_WIDTH];
                slot_id_d        = {grant_idx, seq_q[grant_idx]};
                ptr_d            = grant_idx + REQ_BITS'(1);
                seq_d[grant_idx] = seq_q[grant_idx] + SEQ_W'(1);
            end
        end
        // A flush marker retiring a drained requester overrides any count change.
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (clear_hot[r]) begin
                cnt_d[r] = '0;
            end else if (grant_hot[r] && !resp_hot[r]) begin
                cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (!grant_hot[r] && resp_hot[r] && (cnt_q[r] != '0)) begin
                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            slot_valid_q <= 1'b0;
            slot_addr_q  <= '0;
            slot_id_q    <= '0;
            ptr_q        <= '0;
            for (int unsigned r = 0; r < NUM_REQ; r++) begin
                seq_q[r] <= '0;
                cnt_q[r] <= '0;
            end
        end else begin
            slot_valid_q <= slot_valid_d;
            slot_addr_q  <= slot_addr_d;
            slot_id_q    <= slot_id_d;
            ptr_q        <= ptr_d;
            seq_q        <= seq_d;
            cnt_q        <= cnt_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            busy[r] = (cnt_q[r] != '0) || drain[r];
        end
    end

    assign pl_valid   = slot_valid_q;
    assign pl_address = slot_addr_q;
    assign pl_id      = slot_id_q;

endmodule

// File: tb/tb_pipeline_arbiter.sv
// tb_pipeline_arbiter: directed table-driven checks of pipeline_arbiter (NUM_REQ=4, ID_WIDTH=8),
// plus hand-written sequences for the outstanding limit, seq wrap and flush/drain.
module tb_pipeline_arbiter;
    localparam int NUM_REQ = 4;
    localparam int AW      = 32;
    localparam int IW      = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NUM_REQ*AW-1:0] req_address;
    logic [NUM_REQ-1:0] req_valid, req_stall, req_flush, flush_ack;
    logic [AW-1:0]     resp_address;
    logic [IW-1:0]     resp_id;
    logic [NUM_REQ-1:0] resp_valid, resp_stall, busy;
    logic [AW-1:0]     pl_address;
    logic [IW-1:0]     pl_id;
    logic              pl_valid, pl_stall, pl_flush;
    logic [IW-1:0]     pl_flush_id;
    logic [AW-1:0]     pl_out_address;
    logic [IW-1:0]     pl_out_id;
    logic              pl_out_valid, pl_out_stall, pl_out_flush;

    int checks   = 0;
    int failures = 0;

    pipeline_arbiter #(
        .NUM_REQ      (4),
        .REQ_BITS     (2),
        .MAX_OUT      (8),
        .ADDRESS_WIDTH(32),
        .ID_WIDTH     (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_address   (req_address),
        .req_valid     (req_valid),
        .req_stall     (req_stall),
        .req_flush     (req_flush),
        .flush_ack     (flush_ack),
        .resp_address  (resp_address),
        .resp_id       (resp_id),
        .resp_valid    (resp_valid),
        .resp_stall    (resp_stall),
        .busy          (busy),
        .pl_address    (pl_address),
        .pl_id         (pl_id),
        .pl_valid      (pl_valid),
        .pl_stall      (pl_stall),
        .pl_flush      (pl_flush),
        .pl_flush_id   (pl_flush_id),
        .pl_out_address(pl_out_address),
        .pl_out_id     (pl_out_id),
        .pl_out_valid  (pl_out_valid),
        .pl_out_stall  (pl_out_stall),
        .pl_out_flush  (pl_out_flush)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] rv;
        logic       ps;
        logic       ov;
        logic [7:0] oid;
        logic [3:0] rs;
        logic [3:0] e_rstall;
        logic [3:0] e_rvalid;
        logic       e_ostall;
        logic       e_plv;
        logic [7:0] e_plid;
        logic [3:0] e_busy;
    } vec_t;

    vec_t tab [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic respond(input logic [7:0] id);
        pl_out_valid = 1'b1;
        pl_out_id    = id;
        resp_stall   = '0;
        tick();
        pl_out_valid = 1'b0;
    endtask

    initial begin
        logic [7:0] exp_id;
        logic [7:0] prev_id;
        logic [31:0] exp_addr;

        reset = 1'b0;
        req_valid = 4'hF;
        req_flush = '0;
        resp_stall = '0;
        pl_stall = 1'b0;
        pl_out_valid = 1'b0;
        pl_out_id = '0;
        pl_out_address = 32'hA5A5_0000;
        pl_out_flush = 1'b0;
        for (int r = 0; r < NUM_REQ; r++) req_address[r*AW +: AW] = 32'h1000_0000 + r;

        //            rv   ps   ov   oid    rs     rstall rvalid ostall plv  plid   busy
        tab[0]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 4'hE, 4'h0, 1'b0, 1'b1, 8'h00, 4'h1};
        tab[1]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 4'hD, 4'h0, 1'b0, 1'b1, 8'h40, 4'h3};
        tab[2]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 4'hB, 4'h0, 1'b0, 1'b1, 8'h80, 4'h7};
        tab[3]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 4'h7, 4'h0, 1'b0, 1'b1, 8'hC0, 4'hF};
        tab[4]  = '{4'hF, 1'b0, 1'b0, 8'h00, 4'h0, 4'hE, 4'h0, 1'b0, 1'b1, 8'h01, 4'hF};
        for (int i = 5; i < 10; i++)
            tab[i] = '{4'hF, 1'b1, 1'b1, 8'h80, 4'h4, 4'hF, 4'h4, 1'b1, 1'b1, 8'h01, 4'hF};
        tab[10] = '{4'h0, 1'b0, 1'b1, 8'h80, 4'h0, 4'hF, 4'h4, 1'b0, 1'b0, 8'h00, 4'hB};
        tab[11] = '{4'h0, 1'b0, 1'b1, 8'h41, 4'hD, 4'hF, 4'h2, 1'b0, 1'b0, 8'h00, 4'h9};
        tab[12] = '{4'h0, 1'b0, 1'b1, 8'hC0, 4'h0, 4'hF, 4'h8, 1'b0, 1'b0, 8'h00, 4'h1};
        tab[13] = '{4'h0, 1'b0, 1'b1, 8'h00, 4'h0, 4'hF, 4'h1, 1'b0, 1'b0, 8'h00, 4'h1};
        tab[14] = '{4'h0, 1'b0, 1'b1, 8'h01, 4'h0, 4'hF, 4'h1, 1'b0, 1'b0, 8'h00, 4'h0};

        // Reset held for 3 cycles with every requester valid
        repeat (3) tick();
        chk("rst_pl_valid", pl_valid, 0);
        chk("rst_pl_id", pl_id, 0);
        chk("rst_pl_address", pl_address, 0);
        chk("rst_busy", busy, 0);
        chk("rst_flush_ack", flush_ack, 0);
        chk("rst_pl_flush", pl_flush, 0);
        chk("rst_pl_flush_id", pl_flush_id, 0);
        reset = 1'b1;

        // Round-robin, back-pressure and response routing
        for (int i = 0; i < 15; i++) begin
            req_valid    = tab[i].rv;
            pl_stall     = tab[i].ps;
            pl_out_valid = tab[i].ov;
            pl_out_id    = tab[i].oid;
            resp_stall   = tab[i].rs;
            #1;
            chk($sformatf("tab%0d_req_stall", i), req_stall, tab[i].e_rstall);
            chk($sformatf("tab%0d_resp_valid", i), resp_valid, tab[i].e_rvalid);
            chk($sformatf("tab%0d_pl_out_stall", i), pl_out_stall, tab[i].e_ostall);
            if (tab[i].ov) begin
                chk($sformatf("tab%0d_resp_id", i), resp_id, tab[i].oid);
                chk($sformatf("tab%0d_resp_address", i), resp_address, 32'hA5A5_0000);
            end
            tick();
            chk($sformatf("tab%0d_pl_valid", i), pl_valid, tab[i].e_plv);
            if (tab[i].e_plv) begin
                chk($sformatf("tab%0d_pl_id", i), pl_id, tab[i].e_plid);
                exp_addr = 32'h1000_0000 + 32'(tab[i].e_plid[7:6]);
                chk($sformatf("tab%0d_pl_address", i), pl_address, exp_addr);
            end
            chk($sformatf("tab%0d_busy", i), busy, tab[i].e_busy);
        end
        pl_out_valid = 1'b0;
        resp_stall   = '0;

        // Outstanding limit on r1 (seq1 resumes at 1)
        req_valid = 4'b0010;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk($sformatf("lim%0d_req_stall", i), req_stall, 4'b1101);
            tick();
            exp_id = 8'h41 + 8'(i);
            chk($sformatf("lim%0d_pl_id", i), pl_id, exp_id);
        end
        #1;
        chk("lim_full_stall", req_stall, 4'hF);
        tick();
        chk("lim_full_pl_valid", pl_valid, 0);
        req_valid = 4'b0110;
        #1;
        chk("lim_skip_stall", req_stall, 4'b1011);
        tick();
        chk("lim_skip_pl_id", pl_id, 8'h81);
        req_valid    = 4'b0010;
        pl_out_valid = 1'b1;
        pl_out_id    = 8'h41;
        #1;
        chk("lim_resp_stall_same", req_stall, 4'hF);
        chk("lim_resp_valid", resp_valid, 4'b0010);
        tick();
        pl_out_valid = 1'b0;
        #1;
        chk("lim_regrant_stall", req_stall, 4'b1101);
        tick();
        chk("lim_regrant_pl_id", pl_id, 8'h49);
        req_valid = '0;
        for (int i = 0; i < 8; i++) respond(8'h42 + 8'(i));
        respond(8'h81);
        chk("lim_drained_busy", busy, 0);

        // Seq wrap on r3 with each response returned one cycle after issue
        req_valid = 4'b1000;
        prev_id = '0;
        for (int i = 0; i < 65; i++) begin
            pl_out_valid = (i > 0);
            pl_out_id    = prev_id;
            tick();
            exp_id = 8'hC0 | 8'((1 + i) % 64);
            chk($sformatf("wrap%0d_pl_id", i), pl_id, exp_id);
            prev_id = pl_id;
        end
        req_valid = '0;
        pl_out_valid = 1'b0;
        chk("wrap_busy_one", busy, 4'b1000);
        respond(prev_id);
        chk("wrap_busy_zero", busy, 0);

`ifdef PIPELINE_ARB_FLUSH_EN
        // r2 gets 3 outstanding (seq2 at 2), then r0 and r2 flush together
        req_valid = 4'b0100;
        repeat (3) tick();
        chk("fl_setup_pl_id", pl_id, 8'h84);
        req_valid = '0;
        req_flush = 4'b0101;
        #1;
        chk("fl_ack_not_yet", flush_ack, 0);
        tick();
        chk("fl_r0_ack", flush_ack, 4'b0001);
        chk("fl_r0_pl_flush", pl_flush, 1);
        chk("fl_r0_id", pl_flush_id, 8'h02);
        req_flush = 4'b0100;
        tick();
        chk("fl_r2_ack", flush_ack, 4'b0100);
        chk("fl_r2_pl_flush", pl_flush, 1);
        chk("fl_r2_id", pl_flush_id, 8'h85);
        chk("fl_busy", busy, 4'b0101);
        tick();
        chk("fl_no_reflush_ack", flush_ack, 0);
        chk("fl_no_reflush_pl", pl_flush, 0);
        req_flush = '0;
        req_valid = 4'b0100;
        pl_out_valid = 1'b1;
        pl_out_id = 8'h82;
        resp_stall = 4'b0100;
        #1;
        chk("fl_drain_no_grant", req_stall, 4'hF);
        chk("fl_discard_valid", resp_valid, 0);
        chk("fl_discard_stall", pl_out_stall, 0);
        tick();
        pl_out_valid = 1'b0;
        pl_out_flush = 1'b1;
        tick();
        pl_out_flush = 1'b0;
        chk("fl_first_marker_busy", busy, 4'b0100);
        pl_out_valid = 1'b1;
        pl_out_id = 8'h83;
        #1;
        chk("fl_discard2_valid", resp_valid, 0);
        tick();
        pl_out_valid = 1'b0;
        pl_out_flush = 1'b1;
        tick();
        pl_out_flush = 1'b0;
        resp_stall = '0;
        chk("fl_second_marker_busy", busy, 0);
        #1;
        chk("fl_regrant_stall", req_stall, 4'b1011);
        tick();
        chk("fl_regrant_pl_id", pl_id, 8'h85);
        req_valid = '0;
`else
        req_flush = 4'hF;
        pl_out_flush = 1'b1;
        tick();
        chk("nofl_flush_ack", flush_ack, 0);
        chk("nofl_pl_flush", pl_flush, 0);
        chk("nofl_pl_flush_id", pl_flush_id, 0);
        chk("nofl_busy", busy, 0);
        req_flush = '0;
        pl_out_flush = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_arbiter.md
# pipeline_arbiter

- Shares one `pipeline` instance among `NUM_REQ` requesters.
- Tags each issued transaction with an ID that encodes its requester and a per-requester sequence number.
- Routes pipeline outputs back to the owning requester and enforces a per-requester outstanding limit.
- Forwards per-requester flush requests into the pipeline's flush path; sits directly in front of and behind `pipeline`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters; power of two, at least 2.
- `REQ_BITS`, 2: log2(`NUM_REQ`); occupies the top bits of every ID.
- `MAX_OUT`, 8: maximum in-flight transactions per requester, at most 2^(`ID_WIDTH`-`REQ_BITS`).

Ports (`ADDRESS_WIDTH`, `ID_WIDTH` from `defines.vh`; per-requester buses are flattened, requester r in slice r):
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-low reset.
- `req_address`  in  NUM_REQ*ADDRESS_WIDTH  request addresses.
- `req_valid`  in  NUM_REQ  request valid.
- `req_stall`  out  NUM_REQ  request not accepted this cycle.
- `req_flush`  in  NUM_REQ  flush request, level, held until acked.
- `flush_ack`  out  NUM_REQ  one-cycle flush accept.
- `resp_address`  out  ADDRESS_WIDTH  response address, shared.
- `resp_id`  out  ID_WIDTH  response ID, shared.
- `resp_valid`  out  NUM_REQ  one-hot response valid.
- `resp_stall`  in  NUM_REQ  requester back-pressure.
- `busy`  out  NUM_REQ  requester has transactions outstanding or is draining.
- `pl_address`, `pl_id`, `pl_valid`  out  ADDRESS_WIDTH / ID_WIDTH / 1  to pipeline input.
- `pl_stall`  in  1  pipeline input back-pressure.
- `pl_flush`, `pl_flush_id`  out  1 / ID_WIDTH  to pipeline flush input.
- `pl_out_address`, `pl_out_id`, `pl_out_valid`  in  from pipeline output.
- `pl_out_stall`  out  1  to pipeline output back-pressure.
- `pl_out_flush`  in  1  flush marker emerging from the pipeline.

## Operation
- **Handshake:** transfer happens when valid=1 and stall=0 on the same edge. Valid and payload are held stable while stalled.
- **Issue register:** `pl_address`/`pl_id`/`pl_valid` come from one registered slot. The slot loads when it is empty or `pl_stall`=0.
- **Eligibility:** requester r is eligible when `req_valid[r]`=1, `out_cnt[r]` < `MAX_OUT`, r is not draining, and r is not receiving a flush this cycle.
- **Arbitration:** round-robin. The pointer advances to winner+1 mod `NUM_REQ` after each grant. `req_stall[r]` = !(slot loads and r wins).
- **ID:** `{r[REQ_BITS-1:0], seq[r]}`. `seq[r]` is `ID_WIDTH-REQ_BITS` bits, increments on grant and wraps to 0.
- **Response routing:** o = `pl_out_id[ID_WIDTH-1 -: REQ_BITS]`.
  - `resp_valid[o]` = `pl_out_valid` & !drain[o]; `pl_out_stall` = `resp_stall[o]` & `pl_out_valid`.
  - Responses for a draining requester are discarded: consumed, stall 0.
- **Counters:**
  - `out_cnt[r]` +1 on grant and -1 on a response transfer or discard.
  - A simultaneous grant and response leaves it unchanged.
  - `busy[r]` = `out_cnt[r]`≠0 | drain[r].
- **Flush** (see Configuration): at most one flush per cycle, lowest-index `req_flush` wins.
  - Asserts `pl_flush`=1 and `pl_flush_id`={r, `seq[r]`} for one cycle, plus `flush_ack[r]`.
  - Sets drain[r]; r receives no grants.
  - When `pl_out_flush`=1, the oldest draining requester (flush FIFO order, depth `NUM_REQ`) clears drain and sets `out_cnt`=0.
  - A requester with drain already set does not raise a second flush; its `req_flush` stays unacked.
- **Reset** (reset=0 at an edge):
  - All counters, `seq`, drain, pointer (0) and the slot cleared.
  - `pl_valid`=0, `pl_flush`=0, `pl_flush_id`=0, `pl_address`/`pl_id`=0, `flush_ack`=0, `busy`=0.
  - In-flight responses arriving after reset are dropped only if the pipeline is reset together with this block; this is a system requirement.

## Timing
- Request accepted at edge N; `pl_valid`=1 with that ID after N.
- Response path is combinational: `pl_out_*` to `resp_*` and `resp_stall` to `pl_out_stall` in the same cycle.
- Flush: `req_flush` high at cycle N gives `pl_flush` and `flush_ack` registered, high during N+1.
- `pl_stall`=1 with a full slot: all `req_stall`=1 and the pointer holds.
- `out_cnt`=`MAX_OUT`: requester r stalls and the pointer skips it.
- `seq` wrap from 2^(ID_WIDTH-REQ_BITS)-1 to 0 is legal because `MAX_OUT` keeps IDs unique in flight.

## Configuration
- **`PIPELINE_ARB_FLUSH_EN` defined:** flush logic, drain state and flush FIFO are built as described.
- **Not defined:**
  - `req_flush` and `pl_out_flush` are ignored.
  - `flush_ack`=0, `pl_flush`=0, `pl_flush_id`=0; drain is never set.
  - Eligibility ignores drain, and `busy[r]` = `out_cnt[r]`≠0.

## Test plan
- **Reset:** hold reset=0 for 3 cycles with all `req_valid`=1 -> all outputs 0; first grant after release goes to r=0 with `pl_id`={2'd0, 6'd0} (`ID_WIDTH`=8).
- **Round-robin:** all 4 requesters valid, `pl_stall`=0 -> grants 0,1,2,3,0 on consecutive cycles; r0's second `pl_id`={0,1}.
- **Outstanding limit:** r1 alone valid, `pl_out_valid`=0 -> 8 grants, then `req_stall[1]`=1; one response with `pl_out_id`={1,x} -> next cycle r1 is granted again.
- **Back-pressure:** `pl_stall`=1 for 5 cycles with a full slot -> slot unchanged and all `req_stall`=1. Response for r2 with `resp_stall[2]`=1 -> `pl_out_stall`=1, `out_cnt[2]` unchanged.
- **Seq wrap:** 64 back-to-back grants to r3 with responses returned -> IDs run 0xC0…0xFF then 0xC0.
- **Flush** (`PIPELINE_ARB_FLUSH_EN`): r2 holds 3 outstanding and r0 and r2 raise `req_flush` together -> r0 acked first, r2 the next cycle. r2's responses are discarded until the second `pl_out_flush`, then `busy[2]`=0 and r2 is granted again.
